multiplexor_display_7seg: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the binary-to-BCD converter and takes that converter's four BCD digits (units, tens, hundreds, thousands). The digits are captured into a shadow register on a load strobe, and one digit is scanned per refresh slot. Each scanned digit is decoded to segment patterns, with optional leading-zero suppression.

---
 rtl/multiplexor_display_7seg_if.sv | 24 ++
 rtl/multiplexor_display_7seg.sv | 101 ++++++++++
 tb/tb_multiplexor_display_7seg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/multiplexor_display_7seg_if.sv
// Digit bus from the BCD converter and the scanned display outputs of the 7-segment multiplexer.
// The master side supplies digits and the load strobe; the slave side drives anodes, segments and scan status.
interface multiplexor_display_7seg_if;
    logic       cargar;
    logic [3:0] unidades;
    logic [3:0] decenas;
    logic [3:0] centenas;
    logic [3:0] millares;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       punto;
    logic [1:0] digito_actual;
    logic       fin_barrido;

    modport master (
        output cargar, unidades, decenas, centenas, millares,
        input  anodos, segmentos, punto, digito_actual, fin_barrido
    );

    modport slave (
        input  cargar, unidades, decenas, centenas, millares,
        output anodos, segmentos, punto, digito_actual, fin_barrido
    );
endinterface

// File: rtl/multiplexor_display_7seg.sv
// Purpose: 4-digit time-multiplexed 7-segment driver with a shadow register; optional leading-zero blanking (SUPRESION_CEROS_EN).
// Latency: anodes/segments are registered, 1 cycle behind digito_actual; cargar reaches the display 2 edges later.
// Backpressure: none; cargar is accepted on any edge and the scan free-runs.
module multiplexor_display_7seg #(
    parameter int DIV_REFRESCO = 50000,
    parameter bit ACTIVO_BAJO  = 1'b1
) (
    input logic                        clk,
    input logic                        reset,
    multiplexor_display_7seg_if.slave  bus
);
    localparam int PW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_REFRESCO - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digito_q, digito_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    anodos_q, anodos_d;
    logic [6:0]    seg_q, seg_d;
    logic          fin_q, fin_d;

    logic          fin_slot;
    logic [3:0]    bcd_sel;
    logic          blank;
    logic [6:0]    seg_raw;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    assign fin_slot = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d  = fin_slot ? '0 : presc_q + 1'b1;
        digito_d = fin_slot ? digito_q + 2'd1 : digito_q;
        fin_d    = fin_slot && (digito_q == 2'd3);
        shadow_d = bus.cargar ? {bus.millares, bus.centenas, bus.decenas, bus.unidades}
                              : shadow_q;

        case (digito_q)
            2'd0:    bcd_sel = shadow_q[3:0];
            2'd1:    bcd_sel = shadow_q[7:4];
            2'd2:    bcd_sel = shadow_q[11:8];
            default: bcd_sel = shadow_q[15:12];
        endcase

`ifdef SUPRESION_CEROS_EN
        // Blank a zero digit only when every more-significant digit is zero too; units always show.
        case (digito_q)
            2'd3:    blank = (shadow_q[15:12] == 4'd0);
            2'd2:    blank = (shadow_q[15:8] == 8'd0);
            2'd1:    blank = (shadow_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        seg_raw  = blank ? 7'b0000000 : decode(bcd_sel);
        anodos_d = (4'b0001 << digito_q) ^ {4{ACTIVO_BAJO}};
        seg_d    = seg_raw ^ {7{ACTIVO_BAJO}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            digito_q <= 2'd0;
            shadow_q <= 16'd0;
            anodos_q <= {4{ACTIVO_BAJO}};
            seg_q    <= {7{ACTIVO_BAJO}};
            fin_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digito_q <= digito_d;
            shadow_q <= shadow_d;
            anodos_q <= anodos_d;
            seg_q    <= seg_d;
            fin_q    <= fin_d;
        end
    end

    assign bus.anodos        = anodos_q;
    assign bus.segmentos     = seg_q;
    assign bus.punto         = ACTIVO_BAJO;
    assign bus.digito_actual = digito_q;
    assign bus.fin_barrido   = fin_q;
endmodule

// File: tb/tb_multiplexor_display_7seg.sv
// Scoreboard bench for multiplexor_display_7seg: stimulus queues expected display states, a negedge monitor checks them.
module tb_multiplexor_display_7seg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multiplexor_display_7seg_if bus0 ();
    multiplexor_display_7seg_if bus1 ();

    multiplexor_display_7seg #(.DIV_REFRESCO(4), .ACTIVO_BAJO(1'b1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    multiplexor_display_7seg #(.DIV_REFRESCO(1), .ACTIVO_BAJO(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    localparam logic [6:0] SEG0 = 7'b0000001;
    localparam logic [6:0] SEG1 = 7'b1001111;
    localparam logic [6:0] SEG2 = 7'b0010010;
    localparam logic [6:0] SEG3 = 7'b0000110;
    localparam logic [6:0] SEG4 = 7'b1001100;
    localparam logic [6:0] SEG5 = 7'b0100100;
    localparam logic [6:0] SEG7 = 7'b0001111;
    localparam logic [6:0] SEG8 = 7'b0000000;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] OFF  = 7'b1111111;
`ifdef SUPRESION_CEROS_EN
    localparam logic [6:0] LZ = OFF;
`else
    localparam logic [6:0] LZ = SEG0;
`endif

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fin;
        logic [1:0] dig;
        bit         chk1;
        logic       fin1;
        logic [1:0] dig1;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.name, ".anodos"},    {4'd0, bus0.anodos},        {4'd0, e.an});
            cmp({e.name, ".segmentos"}, {1'b0, bus0.segmentos},     {1'b0, e.seg});
            cmp({e.name, ".fin"},       {7'd0, bus0.fin_barrido},   {7'd0, e.fin});
            cmp({e.name, ".digito"},    {6'd0, bus0.digito_actual}, {6'd0, e.dig});
            cmp({e.name, ".punto"},     {7'd0, bus0.punto},         8'd1);
            if (e.chk1) begin
                cmp({e.name, ".div1_fin"},    {7'd0, bus1.fin_barrido},   {7'd0, e.fin1});
                cmp({e.name, ".div1_digito"}, {6'd0, bus1.digito_actual}, {6'd0, e.dig1});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) step();
    endtask

    task automatic push(input string nm, input logic [3:0] an, input logic [6:0] seg,
                        input logic fin, input logic [1:0] dig,
                        input bit c1, input logic f1, input logic [1:0] d1);
        exp_t e;
        e.name = nm; e.an = an; e.seg = seg; e.fin = fin; e.dig = dig;
        e.chk1 = c1; e.fin1 = f1; e.dig1 = d1;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [3:0] an, input logic [6:0] seg,
                       input logic fin, input logic [1:0] dig);
        step();
        push(nm, an, seg, fin, dig, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic set_dig(input logic [3:0] m, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] u);
        bus0.millares = m; bus0.centenas = c; bus0.decenas = d; bus0.unidades = u;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        chk("reset", 4'b1111, OFF, 1'b0, 2'd0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] segtab [4];
        segtab[0] = SEG1; segtab[1] = SEG2; segtab[2] = SEG3; segtab[3] = SEG4;
        bus0.cargar = 1'b0;
        set_dig(4'd0, 4'd0, 4'd0, 4'd0);
        bus1.cargar = 1'b0;
        bus1.millares = 4'd0; bus1.centenas = 4'd0; bus1.decenas = 4'd0; bus1.unidades = 4'd0;

        // Reset and release: first edge after release shows digit 0 as "0".
        skip(1);
        do_reset();
        chk("release", 4'b1110, SEG0, 1'b0, 2'd0);

        // Full scan of 4,3,2,1 with the DIV_REFRESCO=1 instance checked alongside.
        do_reset();
        set_dig(4'd4, 4'd3, 4'd2, 4'd1);
        bus0.cargar = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            int n;
            logic [3:0] an;
            step();
            if (k == 1) bus0.cargar = 1'b0;
            n  = (k == 17) ? 0 : (k - 1) / 4;
            an = ~(4'b0001 << n);
            push($sformatf("scan%0d", k), an, (k == 1) ? SEG0 : segtab[n],
                 (k == 16), 2'((k / 4) % 4), 1'b1, (k % 4 == 0), 2'(k % 4));
        end

        // Code 12 on the units digit shows a dash.
        do_reset();
        set_dig(4'd0, 4'd0, 4'd0, 4'd12);
        bus0.cargar = 1'b1;
        chk("dash_e1", 4'b1110, SEG0, 1'b0, 2'd0);
        bus0.cargar = 1'b0;
        chk("dash", 4'b1110, DASH, 1'b0, 2'd0);

        // Value 70, live inputs changed without cargar, load on terminal edge, reset mid-slot.
        do_reset();
        set_dig(4'd0, 4'd0, 4'd7, 4'd0);
        bus0.cargar = 1'b1;
        chk("lz_e1", 4'b1110, SEG0, 1'b0, 2'd0);
        bus0.cargar = 1'b0;
        set_dig(4'd9, 4'd9, 4'd9, 4'd9);
        chk("lz_d0", 4'b1110, SEG0, 1'b0, 2'd0);
        skip(3);
        chk("lz_d1", 4'b1101, SEG7, 1'b0, 2'd1);
        skip(3);
        chk("lz_d2", 4'b1011, LZ, 1'b0, 2'd2);
        skip(3);
        chk("lz_d3", 4'b0111, LZ, 1'b0, 2'd3);
        chk("nocargar", 4'b0111, LZ, 1'b0, 2'd3);
        set_dig(4'd8, 4'd8, 4'd8, 4'd5);
        bus0.cargar = 1'b1;
        chk("tc_old", 4'b0111, LZ, 1'b1, 2'd0);
        bus0.cargar = 1'b0;
        chk("tc_new", 4'b1110, SEG5, 1'b0, 2'd0);
        skip(7);
        chk("pre_rst", 4'b1011, SEG8, 1'b0, 2'd2);
        reset = 1'b1;
        bus0.cargar = 1'b1;
        set_dig(4'd9, 4'd9, 4'd9, 4'd9);
        chk("mid_rst", 4'b1111, OFF, 1'b0, 2'd0);
        reset = 1'b0;
        bus0.cargar = 1'b0;
        chk("shadow_clr", 4'b1110, SEG0, 1'b0, 2'd0);

        skip(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
